// File: rtl/key_evt_ctrl.sv
// key_evt_ctrl: turns debounced button levels into a ready/valid stream of key events.
// Build option KEY_EVT_LONG_EN: SHORT/LONG hold classification; otherwise one PRESS event per press edge.
module key_evt_ctrl #(
  parameter int BTN_WIDTH = 8,
  parameter int TICK_DIV  = 27000,
  parameter int LONG_MS   = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BTN_WIDTH-1:0] btn_deb,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [3:0]           evt_idx,
  output logic [1:0]           evt_type,
  output logic                 evt_ovf
);

  if (BTN_WIDTH < 1 || BTN_WIDTH > 16 || TICK_DIV < 1 || LONG_MS < 1 || LONG_MS > 65535) begin : g_param_chk
    $error("key_evt_ctrl: parameter out of range");
  end

  logic                 r_init_done;
  logic [BTN_WIDTH-1:0] r_btn_q;
  logic [BTN_WIDTH-1:0] w_press;
  logic [BTN_WIDTH-1:0] w_gen;
  logic [1:0]           w_gen_type [BTN_WIDTH];
  logic [BTN_WIDTH-1:0] w_accept;
  logic [BTN_WIDTH-1:0] w_ovf_hit;
  logic [15:0]          w_pend16;
  logic [1:0]           w_type16 [16];
  logic                 w_arb_found;
  logic [3:0]           w_arb_idx;
  logic                 r_evt_valid;
  logic [3:0]           r_evt_idx;
  logic [1:0]           r_evt_type;
  logic                 r_evt_ovf;
  logic [3:0]           r_last_grant;

  // Edge-detect register; the first cycle after reset only loads, so a button held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q     <= {BTN_WIDTH{1'b0}};
      r_init_done <= 1'b0;
    end else begin
      r_btn_q     <= btn_deb;
      r_init_done <= 1'b1;
    end
  end

  assign w_press = r_init_done ? (btn_deb & ~r_btn_q) : {BTN_WIDTH{1'b0}};

`ifdef KEY_EVT_LONG_EN
  localparam logic [1:0]  EVT_SHORT = 2'b10;
  localparam logic [1:0]  EVT_LONG  = 2'b11;
  localparam int          TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] LONG_THR  = 16'(LONG_MS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_HELD      = 2'b01,
    ST_LONG_DONE = 2'b10
  } hold_st_t;

  logic [BTN_WIDTH-1:0] w_release;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic                 w_ms_tick;

  assign w_release = r_init_done ? (~btn_deb & r_btn_q) : {BTN_WIDTH{1'b0}};
  assign w_ms_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  // Free-running millisecond divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= {TICK_W{1'b0}};
    end else if (w_ms_tick) begin
      r_tick_cnt <= {TICK_W{1'b0}};
    end else begin
      r_tick_cnt <= r_tick_cnt + {{(TICK_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar gi = 0; gi < BTN_WIDTH; gi++) begin : g_fsm
    hold_st_t    r_state;
    logic [15:0] r_hold;
    logic        w_at_thr;

    assign w_at_thr       = (r_hold == LONG_THR);
    // A release in the threshold cycle still classifies as SHORT.
    assign w_gen[gi]      = (r_state == ST_HELD) & (w_release[gi] | w_at_thr);
    assign w_gen_type[gi] = w_release[gi] ? EVT_SHORT : EVT_LONG;

    // Per-button hold classifier.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_hold  <= 16'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_press[gi]) begin
              r_state <= ST_HELD;
              r_hold  <= 16'd0;
            end
          end
          ST_HELD: begin
            if (w_release[gi]) begin
              r_state <= ST_IDLE;
            end else if (w_at_thr) begin
              r_state <= ST_LONG_DONE;
            end else if (w_ms_tick && (r_hold != 16'hFFFF)) begin
              r_hold <= r_hold + 16'd1;
            end
          end
          ST_LONG_DONE: begin
            if (w_release[gi]) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_hold  <= 16'd0;
          end
        endcase
      end
    end
  end
`else
  localparam logic [1:0] EVT_PRESS = 2'b01;

  assign w_gen = w_press;
  for (genvar gi = 0; gi < BTN_WIDTH; gi++) begin : g_press
    assign w_gen_type[gi] = EVT_PRESS;
  end
`endif

  for (genvar gi = 0; gi < BTN_WIDTH; gi++) begin : g_slot
    logic       r_sv;
    logic [1:0] r_st;

    assign w_accept[gi]  = r_evt_valid & evt_ready & (r_evt_idx == 4'(gi));
    assign w_ovf_hit[gi] = w_gen[gi] & r_sv & ~w_accept[gi];

    // Pending slot: a new event beats a same-cycle acceptance so it is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sv <= 1'b0;
        r_st <= 2'b00;
      end else if (w_gen[gi]) begin
        r_sv <= 1'b1;
        r_st <= w_gen_type[gi];
      end else if (w_accept[gi]) begin
        r_sv <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pad
    if (g < BTN_WIDTH) begin : g_live
      assign w_pend16[g] = g_slot[g].r_sv;
      assign w_type16[g] = g_slot[g].r_st;
    end else begin : g_tie
      assign w_pend16[g] = 1'b0;
      assign w_type16[g] = 2'b00;
    end
  end

  // Round-robin pick: first pending index after the last grant, wrapping at BTN_WIDTH.
  always_comb begin
    logic [4:0] v_sum;
    logic [4:0] v_cand;
    logic       v_hit;
    w_arb_found = 1'b0;
    w_arb_idx   = 4'd0;
    v_sum       = 5'd0;
    v_cand      = 5'd0;
    v_hit       = 1'b0;
    for (int k = 1; k <= BTN_WIDTH; k++) begin
      v_sum       = {1'b0, r_last_grant} + 5'(k);
      v_cand      = (v_sum >= 5'(BTN_WIDTH)) ? (v_sum - 5'(BTN_WIDTH)) : v_sum;
      v_hit       = ~w_arb_found & w_pend16[v_cand[3:0]];
      w_arb_idx   = v_hit ? v_cand[3:0] : w_arb_idx;
      w_arb_found = w_arb_found | v_hit;
    end
  end

  // Output register: holds while stalled, idles one cycle after each acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid  <= 1'b0;
      r_evt_idx    <= 4'd0;
      r_evt_type   <= 2'b00;
      r_evt_ovf    <= 1'b0;
      r_last_grant <= 4'(BTN_WIDTH - 1);
    end else begin
      r_evt_ovf <= |w_ovf_hit;
      if (r_evt_valid) begin
        if (evt_ready) begin
          r_evt_valid  <= 1'b0;
          r_last_grant <= r_evt_idx;
        end
      end else if (w_arb_found) begin
        r_evt_valid <= 1'b1;
        r_evt_idx   <= w_arb_idx;
        r_evt_type  <= w_type16[w_arb_idx];
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_idx   = r_evt_idx;
  assign evt_type  = r_evt_type;
  assign evt_ovf   = r_evt_ovf;

endmodule
